apb_arbiter_2m: RTL and testbench
=================================

# apb_arbiter_2m

Two-master APB arbiter that shares one APB completer between two requesters. Master 0 is the I2C-to-APB adapter; master 1 is a second bus master such as a future SPI bridge or on-chip sequencer. Both masters reach the same 5-bit, 8-bit-data APB target through this block. It owns all completer-side phase sequencing and applies round-robin fairness when both masters request at once. An optional watchdog aborts transfers the completer never finishes.

## Interface
Parameters:
- ADDR_W, 5, APB address width.
- DATA_W, 8, APB data width.
- TIMEOUT_CYCLES, 15, ACCESS cycles allowed before abort (only used with APB_ARB_TIMEOUT_EN); range 1..255.

Ports:
- PCLK  in  1  single clock; all state on rising edge.
- PRESETn  in  1  reset, asynchronous, active-low.
- M0_PSEL, M0_PENABLE, M0_PWRITE  in  1 each  master 0 APB controls.
- M0_PADDR  in  ADDR_W  master 0 address.
- M0_PWDATA  in  DATA_W  master 0 write data.
- M0_PRDATA  out  DATA_W  read data to master 0.
- M0_PREADY  out  1  completion to master 0.
- M0_PSLVERR  out  1  error to master 0.
- M1_*  same set as M0_*  master 1.
- S_PSEL, S_PENABLE, S_PWRITE  out  1 each  completer controls.
- S_PADDR  out  ADDR_W  completer address.
- S_PWDATA  out  DATA_W  completer write data.
- S_PRDATA  in  DATA_W  completer read data.
- S_PREADY  in  1  completer ready.

## Operation
- FSM states: IDLE, SETUP, ACCESS; reset state IDLE.
- Request from master n means Mn_PSEL=1 sampled while the FSM is in IDLE. Mn_PENABLE is ignored for arbitration.
- IDLE:
  - If any request, register grant, PWRITE, PADDR and PWDATA from the granted master, then go to SETUP.
  - Otherwise stay in IDLE.
- SETUP: S_PSEL=1, S_PENABLE=0; unconditionally go to ACCESS.
- ACCESS: S_PSEL=1, S_PENABLE=1.
  - If S_PREADY=1: assert Mgrant_PREADY=1 combinationally that cycle; Mgrant_PRDATA=S_PRDATA; update last_grant; go to IDLE.
  - If S_PREADY=0: stay in ACCESS.
- Arbitration:
  - If only one master requests, it wins.
  - If both request, the master that is not last_grant wins.
  - last_grant resets to 1, so master 0 wins the first tie.
- The non-granted master sees PREADY=0 and PRDATA=0. It is stalled; its request persists because APB requires it to hold its signals.
- S_PADDR, S_PWRITE and S_PWDATA come only from the registered copies. They are stable from SETUP through the end of ACCESS, even if a master misbehaves.
- Mn_PSLVERR=0 except on a timeout abort.
- Reset values:
  - All S_* outputs 0; Mn_PREADY 0; Mn_PRDATA 0; Mn_PSLVERR 0.
  - Grant 0, last_grant 1, timeout counter 0.
- Reset asserted mid-transfer: S_PSEL and S_PENABLE drop to 0 asynchronously, with no completion to the master. The FSM resumes from IDLE after reset release.

## Timing
- Minimum latency: request in IDLE cycle T, SETUP at T+1, ACCESS at T+2.
  - Mn_PREADY=1 at T+2 when S_PREADY=1 (zero wait states). This is one cycle longer than a direct APB connection.
  - Each completer wait state adds one cycle.
- Back-to-back: after completion the FSM spends exactly one cycle in IDLE.
  - A master's next SETUP cycle coincides with that IDLE cycle, so it is sampled immediately.
  - Steady-state throughput is one transfer per 3 cycles.
- A simultaneous request and completion cannot occur: requests are sampled only in IDLE.
- Completion pulse: Mn_PREADY lasts exactly one cycle per granted transfer, and never goes to both masters in the same cycle.

## Configuration
- Macro: APB_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entering ACCESS and increments each ACCESS cycle with S_PREADY=0.
  - When the count reaches TIMEOUT_CYCLES and S_PREADY is still 0, the arbiter aborts that cycle. It asserts Mgrant_PREADY=1 and Mgrant_PSLVERR=1 with Mgrant_PRDATA=0, updates last_grant, and returns to IDLE. S_PSEL drops to 0 the next cycle.
  - If S_PREADY=1 in the same cycle as expiry, normal completion wins and PSLVERR=0.
- Undefined: no counter is present; the arbiter waits indefinitely for S_PREADY; Mn_PSLVERR is tied to 0.

## Test plan
- Single read: M0 reads addr 5, completer returns 0xA5 with 0 waits → S_PSEL at T+1, S_PENABLE at T+2, M0_PREADY=1 and M0_PRDATA=0xA5 at T+2; M1_PREADY stays 0.
- Tie: M0 and M1 both request in the same cycle after reset → M0 served first, M1 second. On the next tie M0 is served first again, since M1 is now last_grant; alternation continues on each tie.
- Wait states: M1 writes 0x3C to addr 0x1F, completer holds PREADY=0 for 4 cycles → S_PADDR=0x1F and S_PWDATA=0x3C stable throughout; M1_PREADY at T+6.
- Back-to-back: M0 issues 3 writes continuously with 0-wait completer → completions at T+2, T+5, T+8.
- Reset mid-ACCESS: PRESETn low during a stalled transfer → S_PSEL and S_PENABLE go to 0 without a clock edge, no PREADY pulse. After release, a fresh M1 request completes normally.
- With APB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=15, completer never ready → M0_PREADY=1 and M0_PSLVERR=1 with PRDATA=0 after 15 stalled ACCESS cycles; without the macro, still waiting after 100 cycles.

Source files
------------

// File: rtl/apb_arbiter_2m.sv
// apb_arbiter_2m: shares one APB completer between two APB requesters.
// Master 0 is the I2C-to-APB adapter, master 1 a second bus master.
// The arbiter owns completer-side SETUP/ACCESS sequencing and applies
// round-robin priority when both masters request in the same IDLE cycle.
// Optional feature macro: APB_ARB_TIMEOUT_EN adds a watchdog that aborts
// an ACCESS phase the completer never finishes, answering with PSLVERR.
module apb_arbiter_2m #(
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              M0_PSEL,
  input  logic              M0_PENABLE,
  input  logic              M0_PWRITE,
  input  logic [ADDR_W-1:0] M0_PADDR,
  input  logic [DATA_W-1:0] M0_PWDATA,
  output logic [DATA_W-1:0] M0_PRDATA,
  output logic              M0_PREADY,
  output logic              M0_PSLVERR,
  input  logic              M1_PSEL,
  input  logic              M1_PENABLE,
  input  logic              M1_PWRITE,
  input  logic [ADDR_W-1:0] M1_PADDR,
  input  logic [DATA_W-1:0] M1_PWDATA,
  output logic [DATA_W-1:0] M1_PRDATA,
  output logic              M1_PREADY,
  output logic              M1_PSLVERR,
  output logic              S_PSEL,
  output logic              S_PENABLE,
  output logic              S_PWRITE,
  output logic [ADDR_W-1:0] S_PADDR,
  output logic [DATA_W-1:0] S_PWDATA,
  input  logic [DATA_W-1:0] S_PRDATA,
  input  logic              S_PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              abort;
  logic              ok_done;
  logic              xfer_end;

  // Arbitration only looks at PSEL; PENABLE carries no extra information here.
  logic unused_penable;
  assign unused_penable = M0_PENABLE ^ M1_PENABLE;

`ifdef APB_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;

  // Abort in the stalled ACCESS cycle that brings the count to TIMEOUT_CYCLES;
  // a simultaneous S_PREADY takes precedence as a normal completion.
  assign abort = (state_q == ACCESS) && !S_PREADY && (cnt_q == TO_LAST);

  // Watchdog count of stalled ACCESS cycles, cleared on the way into ACCESS.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SETUP) begin
      cnt_d = '0;
    end else if ((state_q == ACCESS) && !S_PREADY) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT_CYCLES);
  assign abort          = 1'b0;
`endif

  assign ok_done  = (state_q == ACCESS) && S_PREADY;
  assign xfer_end = ok_done || abort;

  // Next-state logic: arbitrate and capture the request in IDLE, then walk SETUP/ACCESS.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    case (state_q)
      IDLE: begin
        if (M0_PSEL || M1_PSEL) begin
          // On a tie the master that was not served last wins.
          if (M0_PSEL && M1_PSEL) begin
            grant_d = ~last_grant_q;
          end else begin
            grant_d = M1_PSEL;
          end
          pwrite_d = grant_d ? M1_PWRITE : M0_PWRITE;
          paddr_d  = grant_d ? M1_PADDR  : M0_PADDR;
          pwdata_d = grant_d ? M1_PWDATA : M0_PWDATA;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (xfer_end) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, grant and captured-request registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
    end
  end

  // Completer side is driven purely from state and the captured copies.
  assign S_PSEL    = (state_q != IDLE);
  assign S_PENABLE = (state_q == ACCESS);
  assign S_PWRITE  = pwrite_q;
  assign S_PADDR   = paddr_q;
  assign S_PWDATA  = pwdata_q;

  // Requester side: only the granted master ever sees completion or data.
  assign M0_PREADY  = xfer_end && !grant_q;
  assign M1_PREADY  = xfer_end &&  grant_q;
  assign M0_PSLVERR = abort && !grant_q;
  assign M1_PSLVERR = abort &&  grant_q;
  assign M0_PRDATA  = (ok_done && !grant_q) ? S_PRDATA : '0;
  assign M1_PRDATA  = (ok_done &&  grant_q) ? S_PRDATA : '0;

endmodule

// File: tb/tb_apb_arbiter_2m.sv
// Directed testbench for apb_arbiter_2m (default parameters).
module tb_apb_arbiter_2m;

  logic       PCLK;
  logic       PRESETn;
  logic       M0_PSEL, M0_PENABLE, M0_PWRITE;
  logic [4:0] M0_PADDR;
  logic [7:0] M0_PWDATA, M0_PRDATA;
  logic       M0_PREADY, M0_PSLVERR;
  logic       M1_PSEL, M1_PENABLE, M1_PWRITE;
  logic [4:0] M1_PADDR;
  logic [7:0] M1_PWDATA, M1_PRDATA;
  logic       M1_PREADY, M1_PSLVERR;
  logic       S_PSEL, S_PENABLE, S_PWRITE;
  logic [4:0] S_PADDR;
  logic [7:0] S_PWDATA, S_PRDATA;
  logic       S_PREADY;

  int total = 0;
  int bad   = 0;

  apb_arbiter_2m dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .M0_PSEL(M0_PSEL), .M0_PENABLE(M0_PENABLE), .M0_PWRITE(M0_PWRITE),
    .M0_PADDR(M0_PADDR), .M0_PWDATA(M0_PWDATA), .M0_PRDATA(M0_PRDATA),
    .M0_PREADY(M0_PREADY), .M0_PSLVERR(M0_PSLVERR),
    .M1_PSEL(M1_PSEL), .M1_PENABLE(M1_PENABLE), .M1_PWRITE(M1_PWRITE),
    .M1_PADDR(M1_PADDR), .M1_PWDATA(M1_PWDATA), .M1_PRDATA(M1_PRDATA),
    .M1_PREADY(M1_PREADY), .M1_PSLVERR(M1_PSLVERR),
    .S_PSEL(S_PSEL), .S_PENABLE(S_PENABLE), .S_PWRITE(S_PWRITE),
    .S_PADDR(S_PADDR), .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA),
    .S_PREADY(S_PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Advance to 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge PCLK);
    #2;
  endtask

  task automatic clear_inputs();
    M0_PSEL = 0; M0_PENABLE = 0; M0_PWRITE = 0; M0_PADDR = '0; M0_PWDATA = '0;
    M1_PSEL = 0; M1_PENABLE = 0; M1_PWRITE = 0; M1_PADDR = '0; M1_PWDATA = '0;
    S_PRDATA = '0; S_PREADY = 0;
  endtask

  task automatic do_reset();
    PRESETn = 0;
    clear_inputs();
    cyc();
    cyc();
    @(negedge PCLK);
    PRESETn = 1;
    cyc();
  endtask

  task automatic test_reset();
    clear_inputs();
    PRESETn = 0;
    #3;
    total++;
    if ({S_PSEL, S_PENABLE, S_PWRITE, S_PADDR, S_PWDATA, M0_PREADY, M0_PSLVERR, M0_PRDATA,
         M1_PREADY, M1_PSLVERR, M1_PRDATA} !== 36'd0) begin
      bad++;
      $display("FAIL reset_outputs got S_PSEL=%b S_PENABLE=%b M0_PREADY=%b M1_PREADY=%b want all zero",
               S_PSEL, S_PENABLE, M0_PREADY, M1_PREADY);
    end
    M0_PSEL = 1; S_PREADY = 1;
    cyc();
    cyc();
    total++;
    if ({S_PSEL, S_PENABLE, M0_PREADY} !== 3'b000) begin
      bad++;
      $display("FAIL reset_hold got %b want 000", {S_PSEL, S_PENABLE, M0_PREADY});
    end
    M0_PSEL = 0; S_PREADY = 0;
    @(negedge PCLK);
    PRESETn = 1;
    cyc();
    total++;
    if (S_PSEL !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_idle S_PSEL=%b want 0", S_PSEL);
    end
  endtask

  task automatic test_single_read();
    M0_PSEL = 1; M0_PWRITE = 0; M0_PADDR = 5'd5; S_PREADY = 1; S_PRDATA = 8'hA5;
    #1;
    total++;
    if (S_PSEL !== 1'b0) begin
      bad++;
      $display("FAIL read_T S_PSEL=%b want 0", S_PSEL);
    end
    cyc();
    M0_PENABLE = 1;
    total++;
    if ({S_PSEL, S_PENABLE, S_PWRITE, S_PADDR, M0_PREADY} !== {3'b100, 5'd5, 1'b0}) begin
      bad++;
      $display("FAIL read_setup got %b want %b", {S_PSEL, S_PENABLE, S_PWRITE, S_PADDR, M0_PREADY},
               {3'b100, 5'd5, 1'b0});
    end
    cyc();
    total++;
    if ({S_PSEL, S_PENABLE, M0_PREADY, M0_PSLVERR, M0_PRDATA} !== {4'b1110, 8'hA5}) begin
      bad++;
      $display("FAIL read_access got sel=%b en=%b rdy=%b err=%b rdata=%h want 1 1 1 0 a5",
               S_PSEL, S_PENABLE, M0_PREADY, M0_PSLVERR, M0_PRDATA);
    end
    total++;
    if ({M1_PREADY, M1_PRDATA} !== 9'd0) begin
      bad++;
      $display("FAIL read_other_master M1_PREADY=%b M1_PRDATA=%h want 0 00", M1_PREADY, M1_PRDATA);
    end
    M0_PSEL = 0; M0_PENABLE = 0;
    cyc();
    total++;
    if ({S_PSEL, M0_PREADY} !== 2'b00) begin
      bad++;
      $display("FAIL read_back_idle got %b want 00", {S_PSEL, M0_PREADY});
    end
  endtask

  task automatic test_tie();
    do_reset();
    S_PREADY = 1; S_PRDATA = 8'h11;
    M0_PSEL = 1; M0_PADDR = 5'd1; M1_PSEL = 1; M1_PADDR = 5'd2;
    cyc();
    total++;
    if (S_PADDR !== 5'd1) begin
      bad++;
      $display("FAIL tie1_grant S_PADDR=%h want 01", S_PADDR);
    end
    cyc();
    total++;
    if ({M0_PREADY, M1_PREADY} !== 2'b10) begin
      bad++;
      $display("FAIL tie1_done got %b want 10", {M0_PREADY, M1_PREADY});
    end
    M0_PSEL = 0;
    cyc();
    cyc();
    total++;
    if (S_PADDR !== 5'd2) begin
      bad++;
      $display("FAIL tie1_second S_PADDR=%h want 02", S_PADDR);
    end
    cyc();
    total++;
    if ({M0_PREADY, M1_PREADY} !== 2'b01) begin
      bad++;
      $display("FAIL tie1_second_done got %b want 01", {M0_PREADY, M1_PREADY});
    end
    M0_PSEL = 1; M0_PADDR = 5'd3; M1_PADDR = 5'd4;
    cyc();
    cyc();
    total++;
    if (S_PADDR !== 5'd3) begin
      bad++;
      $display("FAIL tie2_grant S_PADDR=%h want 03", S_PADDR);
    end
    cyc();
    total++;
    if ({M0_PREADY, M1_PREADY} !== 2'b10) begin
      bad++;
      $display("FAIL tie2_done got %b want 10", {M0_PREADY, M1_PREADY});
    end
    M0_PSEL = 0;
    cyc();
    cyc();
    total++;
    if (S_PADDR !== 5'd4) begin
      bad++;
      $display("FAIL tie2_second S_PADDR=%h want 04", S_PADDR);
    end
    cyc();
    total++;
    if ({M0_PREADY, M1_PREADY} !== 2'b01) begin
      bad++;
      $display("FAIL tie2_second_done got %b want 01", {M0_PREADY, M1_PREADY});
    end
    M0_PSEL = 1; M0_PADDR = 5'd5; M1_PADDR = 5'd6;
    cyc();
    cyc();
    total++;
    if (S_PADDR !== 5'd5) begin
      bad++;
      $display("FAIL tie3_grant S_PADDR=%h want 05", S_PADDR);
    end
    cyc();
    total++;
    if ({M0_PREADY, M1_PREADY} !== 2'b10) begin
      bad++;
      $display("FAIL tie3_done got %b want 10", {M0_PREADY, M1_PREADY});
    end
    M0_PSEL = 0; M1_PSEL = 0;
    cyc();
  endtask

  task automatic test_wait_states();
    M1_PSEL = 1; M1_PWRITE = 1; M1_PADDR = 5'h1F; M1_PWDATA = 8'h3C; S_PREADY = 0;
    cyc();
    M1_PENABLE = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      // A misbehaving master changing its bus must not reach the completer.
      M1_PADDR = 5'h00; M1_PWDATA = 8'hFF; M1_PWRITE = 0;
      #1;
      total++;
      if ({S_PSEL, S_PENABLE, S_PWRITE, S_PADDR, S_PWDATA, M1_PREADY} !== {3'b111, 5'h1F, 8'h3C, 1'b0}) begin
        bad++;
        $display("FAIL wait_stable[%0d] addr=%h wdata=%h wr=%b rdy=%b want 1f 3c 1 0",
                 i, S_PADDR, S_PWDATA, S_PWRITE, M1_PREADY);
      end
    end
    cyc();
    S_PREADY = 1;
    #1;
    total++;
    if ({M1_PREADY, M1_PSLVERR, M0_PREADY, S_PADDR} !== {3'b100, 5'h1F}) begin
      bad++;
      $display("FAIL wait_done got rdy=%b err=%b m0rdy=%b addr=%h want 1 0 0 1f",
               M1_PREADY, M1_PSLVERR, M0_PREADY, S_PADDR);
    end
    M1_PSEL = 0; M1_PENABLE = 0; M1_PWRITE = 0;
    cyc();
    total++;
    if ({S_PSEL, M1_PREADY} !== 2'b00) begin
      bad++;
      $display("FAIL wait_back_idle got %b want 00", {S_PSEL, M1_PREADY});
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic exp_rdy;
    logic [4:0] a;
    logic [7:0] d;
    n = 0;
    a = 5'h10; d = 8'h01;
    M0_PSEL = 1; M0_PWRITE = 1; M0_PADDR = a; M0_PWDATA = d; S_PREADY = 1;
    for (int idx = 1; idx <= 9; idx++) begin
      cyc();
      exp_rdy = (idx == 2) || (idx == 5) || (idx == 8);
      total++;
      if (exp_rdy) begin
        if ({M0_PREADY, S_PADDR, S_PWDATA} !== {1'b1, a, d}) begin
          bad++;
          $display("FAIL b2b_done[T+%0d] rdy=%b addr=%h wdata=%h want 1 %h %h",
                   idx, M0_PREADY, S_PADDR, S_PWDATA, a, d);
        end
        n++;
        a = a + 5'd1; d = d + 8'd1;
        M0_PADDR = a; M0_PWDATA = d;
        if (n == 3) M0_PSEL = 0;
      end else begin
        if (M0_PREADY !== 1'b0) begin
          bad++;
          $display("FAIL b2b_idle[T+%0d] M0_PREADY=%b want 0", idx, M0_PREADY);
        end
      end
    end
    M0_PWRITE = 0;
  endtask

  task automatic test_reset_mid_access();
    M0_PSEL = 1; M0_PADDR = 5'd7; S_PREADY = 0;
    cyc();
    cyc();
    cyc();
    #1;
    PRESETn = 0;
    S_PREADY = 1;
    #1;
    total++;
    if ({S_PSEL, S_PENABLE, M0_PREADY, M1_PREADY} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_mid_async got %b want 0000", {S_PSEL, S_PENABLE, M0_PREADY, M1_PREADY});
    end
    M0_PSEL = 0;
    cyc();
    @(negedge PCLK);
    PRESETn = 1;
    cyc();
    M1_PSEL = 1; M1_PWRITE = 0; M1_PADDR = 5'd9; S_PRDATA = 8'h5A; S_PREADY = 1;
    cyc();
    total++;
    if ({S_PSEL, S_PENABLE, S_PADDR} !== {2'b10, 5'd9}) begin
      bad++;
      $display("FAIL reset_mid_resume_setup sel=%b en=%b addr=%h want 1 0 09", S_PSEL, S_PENABLE, S_PADDR);
    end
    cyc();
    total++;
    if ({M1_PREADY, M1_PRDATA, M0_PREADY} !== {1'b1, 8'h5A, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid_resume_done rdy=%b rdata=%h m0rdy=%b want 1 5a 0",
               M1_PREADY, M1_PRDATA, M0_PREADY);
    end
    M1_PSEL = 0;
    cyc();
  endtask

  task automatic test_timeout();
    do_reset();
    M0_PSEL = 1; M0_PWRITE = 0; M0_PADDR = 5'd3; S_PREADY = 0; S_PRDATA = 8'hEE;
    cyc();
`ifdef APB_ARB_TIMEOUT_EN
    for (int k = 1; k <= 15; k++) begin
      cyc();
      total++;
      if (k < 15) begin
        if ({S_PENABLE, M0_PREADY, M0_PSLVERR} !== 3'b100) begin
          bad++;
          $display("FAIL timeout_stall[%0d] got %b want 100", k, {S_PENABLE, M0_PREADY, M0_PSLVERR});
        end
      end else begin
        if ({M0_PREADY, M0_PSLVERR, M0_PRDATA, M1_PREADY} !== {2'b11, 8'h00, 1'b0}) begin
          bad++;
          $display("FAIL timeout_abort rdy=%b err=%b rdata=%h m1rdy=%b want 1 1 00 0",
                   M0_PREADY, M0_PSLVERR, M0_PRDATA, M1_PREADY);
        end
      end
    end
    M0_PSEL = 0;
    cyc();
    total++;
    if ({S_PSEL, M0_PREADY} !== 2'b00) begin
      bad++;
      $display("FAIL timeout_release got %b want 00", {S_PSEL, M0_PREADY});
    end
`else
    for (int k = 1; k <= 100; k++) begin
      cyc();
      total++;
      if ({S_PSEL, S_PENABLE, M0_PREADY, M0_PSLVERR} !== 4'b1100) begin
        bad++;
        $display("FAIL no_timeout_wait[%0d] got %b want 1100", k, {S_PSEL, S_PENABLE, M0_PREADY, M0_PSLVERR});
      end
    end
    M0_PSEL = 0;
    S_PREADY = 1;
    #1;
    total++;
    if ({M0_PREADY, M0_PSLVERR, M0_PRDATA} !== {2'b10, 8'hEE}) begin
      bad++;
      $display("FAIL no_timeout_late_done rdy=%b err=%b rdata=%h want 1 0 ee", M0_PREADY, M0_PSLVERR, M0_PRDATA);
    end
    cyc();
`endif
  endtask

  initial begin
    PRESETn = 0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_tie();
    test_wait_states();
    test_back_to_back();
    test_reset_mid_access();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
